mps_aie_trip: RTL and testbench

MPS_AIE_TRIP -- requirements
Module: mps_aie_trip

---
 rtl/mps_aie_trip.sv | 176 +++++++++++++++++
 tb/tb_mps_aie_trip.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mps_aie_trip.sv
// Purpose : beam-abort interlock trip FSM; latches trip_out after persist_n consecutive violating samples.
// Latency : trip_out, cause_o and fault_* register 1 clk after the tripping sample.
// Backpressure: none; a sample is taken on any cycle with datavalid & il_valid, otherwise state holds.
//
// Ports:
//   clk, RESET_N          clock, async active-low reset (synchronous release)
//   enable, clear         arm / one-cycle trip clear from uBlaze
//   datavalid, il_valid   sample qualifiers from the cal stage
//   x_il, y_il            per-axis limit violations; x_err, y_err signed errors captured on trip
//   persist_n             consecutive violating samples required to trip (0 behaves as 1)
//   trip_out, state_o, cause_o, fault_x_err, fault_y_err, trip_count, pend_cnt   status outputs
// Optional: define MPS_AIE_TRIP_TIMEOUT_EN to add a datavalid watchdog (TIMEOUT_CYCLES) that trips with cause 11.
module mps_aie_trip #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic             clk,
   input  logic             RESET_N,
   input  logic             enable,
   input  logic             datavalid,
   input  logic             il_valid,
   input  logic             x_il,
   input  logic             y_il,
   input  logic [31:0]      x_err,
   input  logic [31:0]      y_err,
   input  logic [CNT_W-1:0] persist_n,
   input  logic             clear,
   output logic             trip_out,
   output logic [1:0]       state_o,
   output logic [1:0]       cause_o,
   output logic [31:0]      fault_x_err,
   output logic [31:0]      fault_y_err,
   output logic [CNT_W-1:0] trip_count,
   output logic [CNT_W-1:0] pend_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      PENDING = 2'b10,
      TRIPPED = 2'b11
   } state_t;

   state_t           state, state_nx;
   logic             trip_nx;
   logic [1:0]       cause_nx;
   logic [31:0]      fx_nx, fy_nx;
   logic [CNT_W-1:0] pend_nx;
   logic [CNT_W-1:0] trip_count_nx;
   logic [CNT_W-1:0] cand;
   logic             trip_entry;

   logic             sample;
   logic             viol;
   logic             wd_hit;
   logic [CNT_W-1:0] eff_persist;

   assign sample      = datavalid & il_valid;
   assign viol        = x_il | y_il;
   assign eff_persist = (persist_n == '0) ? CNT_W'(1) : persist_n;
   assign state_o     = state;

`ifdef MPS_AIE_TRIP_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            wd_active;

   assign wd_active = (state == ARMED) || (state == PENDING);
   // Reaching the limit means this is the TIMEOUT_CYCLES-th sample-less cycle in ARMED/PENDING.
   assign wd_hit    = wd_active && !sample && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         wd_cnt <= '0;
      end else if (!wd_active || sample) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_nx   = state;
      trip_nx    = trip_out;
      cause_nx   = cause_o;
      fx_nx      = fault_x_err;
      fy_nx      = fault_y_err;
      pend_nx    = pend_cnt;
      trip_entry = 1'b0;
      cand       = '0;

      case (state)
         IDLE: begin
            pend_nx = '0;
            if (enable) state_nx = ARMED;
         end
         ARMED, PENDING: begin
            // Priority: disarm, then clear, then sample, then watchdog.
            if (!enable) begin
               state_nx = IDLE;
               pend_nx  = '0;
            end else if (clear) begin
               state_nx = ARMED;
               pend_nx  = '0;
            end else if (sample) begin
               if (viol) begin
                  cand    = (state == ARMED) ? CNT_W'(1) : pend_cnt + CNT_W'(1);
                  pend_nx = cand;
                  // persist_n is compared live, so a lowered setting trips on the next violation.
                  if (cand >= eff_persist) begin
                     state_nx   = TRIPPED;
                     trip_nx    = 1'b1;
                     cause_nx   = {y_il, x_il};
                     fx_nx      = x_err;
                     fy_nx      = y_err;
                     trip_entry = 1'b1;
                  end else begin
                     state_nx = PENDING;
                  end
               end else begin
                  state_nx = ARMED;
                  pend_nx  = '0;
               end
            end else if (wd_hit) begin
               state_nx   = TRIPPED;
               trip_nx    = 1'b1;
               cause_nx   = 2'b11;
               fx_nx      = '0;
               fy_nx      = '0;
               trip_entry = 1'b1;
            end
         end
         TRIPPED: begin
            // Latched until clear; enable and samples are ignored here.
            if (clear) begin
               state_nx = enable ? ARMED : IDLE;
               trip_nx  = 1'b0;
               cause_nx = 2'b00;
               fx_nx    = '0;
               fy_nx    = '0;
               pend_nx  = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      trip_count_nx = trip_count;
      if (trip_entry && (trip_count != '1)) trip_count_nx = trip_count + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         trip_out    <= 1'b0;
         cause_o     <= 2'b00;
         fault_x_err <= '0;
         fault_y_err <= '0;
         trip_count  <= '0;
         pend_cnt    <= '0;
      end else begin
         state       <= state_nx;
         trip_out    <= trip_nx;
         cause_o     <= cause_nx;
         fault_x_err <= fx_nx;
         fault_y_err <= fy_nx;
         trip_count  <= trip_count_nx;
         pend_cnt    <= pend_nx;
      end
   end

endmodule

// File: tb/tb_mps_aie_trip.sv
// Purpose : directed table-driven bench for mps_aie_trip plus reset, saturation and watchdog sequences.
// Latency : outputs checked 1 time unit after each rising edge.
// Backpressure: none; inputs driven on the falling edge.
module tb_mps_aie_trip;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          RESET_N;
   logic          enable, datavalid, il_valid, x_il, y_il, clear;
   logic [31:0]   x_err, y_err;
   logic [CW-1:0] persist_n;
   logic          trip_out;
   logic [1:0]    state_o, cause_o;
   logic [31:0]   fault_x_err, fault_y_err;
   logic [CW-1:0] trip_count, pend_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   mps_aie_trip #(.CNT_W(CW), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .RESET_N(RESET_N), .enable(enable), .datavalid(datavalid),
      .il_valid(il_valid), .x_il(x_il), .y_il(y_il), .x_err(x_err), .y_err(y_err),
      .persist_n(persist_n), .clear(clear), .trip_out(trip_out), .state_o(state_o),
      .cause_o(cause_o), .fault_x_err(fault_x_err), .fault_y_err(fault_y_err),
      .trip_count(trip_count), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          en, dv, ilv, xil, yil, clr;
      logic [CW-1:0] persist;
      logic [31:0]   xe, ye;
      logic [1:0]    st;
      logic          trip;
      logic [1:0]    cause;
      logic [CW-1:0] pend;
      logic          chkp;
      logic [CW-1:0] tc;
      logic [31:0]   fx, fy;
   } vec_t;

   function automatic vec_t mk(input logic en, dv, ilv, xil, yil, clr, input logic [CW-1:0] persist,
                               input logic [31:0] xe, ye, input logic [1:0] st, input logic trip,
                               input logic [1:0] cause, input logic [CW-1:0] pend, input logic chkp,
                               input logic [CW-1:0] tc, input logic [31:0] fx, fy);
      vec_t v;
      v.en = en; v.dv = dv; v.ilv = ilv; v.xil = xil; v.yil = yil; v.clr = clr;
      v.persist = persist; v.xe = xe; v.ye = ye; v.st = st; v.trip = trip; v.cause = cause;
      v.pend = pend; v.chkp = chkp; v.tc = tc; v.fx = fx; v.fy = fy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, dv, ilv, xil, yil, clr, input logic [CW-1:0] persist,
                        input logic [31:0] xe, ye);
      @(negedge clk);
      enable = en; datavalid = dv; il_valid = ilv; x_il = xil; y_il = yil; clear = clr;
      persist_n = persist; x_err = xe; y_err = ye;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " state"}, 32'(state_o), 32'h0);
      chk({tag, " trip_out"}, 32'(trip_out), 32'h0);
      chk({tag, " cause"}, 32'(cause_o), 32'h0);
      chk({tag, " fault_x"}, fault_x_err, 32'h0);
      chk({tag, " fault_y"}, fault_y_err, 32'h0);
      chk({tag, " trip_count"}, 32'(trip_count), 32'h0);
      chk({tag, " pend_cnt"}, 32'(pend_cnt), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout: got running, expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      vec_t vt[$];
      logic [CW-1:0] exp_tc;

      // Persistence 3 trip with x cause, then clear back to ARMED.
      vt.push_back(mk(1,0,0,0,0,0,3,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd0,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,3,32'h1388,32'h0,      2'd2,0,2'd0,4'd1,1,4'd0,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,3,32'h1388,32'h0,      2'd2,0,2'd0,4'd2,1,4'd0,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,3,32'h1388,32'h0,      2'd3,1,2'd1,4'd0,0,4'd1,32'h1388,32'h0));
      vt.push_back(mk(1,0,0,0,0,1,3,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd1,32'h0,32'h0));
      // viol, viol, clean, viol, viol -> pend 1,2,0,1,2; il_valid=0 is not a sample.
      vt.push_back(mk(1,1,1,1,0,0,3,32'h0,32'h0,         2'd2,0,2'd0,4'd1,1,4'd1,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,3,32'h0,32'h0,         2'd2,0,2'd0,4'd2,1,4'd1,32'h0,32'h0));
      vt.push_back(mk(1,1,1,0,0,0,3,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd1,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,3,32'h0,32'h0,         2'd2,0,2'd0,4'd1,1,4'd1,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,3,32'h0,32'h0,         2'd2,0,2'd0,4'd2,1,4'd1,32'h0,32'h0));
      vt.push_back(mk(1,1,0,1,0,0,3,32'h0,32'h0,         2'd2,0,2'd0,4'd2,1,4'd1,32'h0,32'h0));
      vt.push_back(mk(1,1,1,0,0,0,3,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd1,32'h0,32'h0));
      // persist_n=0 behaves as 1: single y violation trips.
      vt.push_back(mk(1,1,1,0,1,0,0,32'h10,32'hFFFFFF38, 2'd3,1,2'd2,4'd0,0,4'd2,32'h10,32'hFFFFFF38));
      // TRIPPED ignores enable=0 and samples; clear wins over a viol sample, enable=0 -> IDLE.
      vt.push_back(mk(0,1,1,1,0,0,0,32'h5,32'h6,         2'd3,1,2'd2,4'd0,0,4'd2,32'h10,32'hFFFFFF38));
      vt.push_back(mk(0,1,1,1,0,1,0,32'h5,32'h6,         2'd0,0,2'd0,4'd0,1,4'd2,32'h0,32'h0));
      vt.push_back(mk(0,0,0,0,0,1,0,32'h0,32'h0,         2'd0,0,2'd0,4'd0,1,4'd2,32'h0,32'h0));
      // Mid-run persistence decrease below pend_cnt trips on next violation.
      vt.push_back(mk(1,0,0,0,0,0,5,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd2,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,5,32'h0,32'h0,         2'd2,0,2'd0,4'd1,1,4'd2,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,5,32'h0,32'h0,         2'd2,0,2'd0,4'd2,1,4'd2,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,2,32'h7FFFFFFF,32'h1,  2'd3,1,2'd1,4'd0,0,4'd3,32'h7FFFFFFF,32'h1));
      vt.push_back(mk(1,0,0,0,0,1,5,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd3,32'h0,32'h0));
      // enable=0 beats a viol sample; clear in PENDING returns to ARMED.
      vt.push_back(mk(1,1,1,1,0,0,5,32'h0,32'h0,         2'd2,0,2'd0,4'd1,1,4'd3,32'h0,32'h0));
      vt.push_back(mk(0,1,1,1,0,0,5,32'h0,32'h0,         2'd0,0,2'd0,4'd0,1,4'd3,32'h0,32'h0));
      vt.push_back(mk(1,0,0,0,0,0,5,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd3,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,0,5,32'h0,32'h0,         2'd2,0,2'd0,4'd1,1,4'd3,32'h0,32'h0));
      vt.push_back(mk(1,1,1,1,0,1,5,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd3,32'h0,32'h0));
      // Both axes violate -> cause 11.
      vt.push_back(mk(1,1,1,1,1,0,1,32'hA,32'hB,         2'd3,1,2'd3,4'd0,0,4'd4,32'hA,32'hB));
      vt.push_back(mk(1,0,0,0,0,1,1,32'h0,32'h0,         2'd1,0,2'd0,4'd0,1,4'd4,32'h0,32'h0));

      RESET_N = 1'b0; enable = 0; datavalid = 0; il_valid = 0; x_il = 0; y_il = 0; clear = 0;
      persist_n = '0; x_err = '0; y_err = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      RESET_N = 1'b1;

      foreach (vt[i]) begin
         drive(vt[i].en, vt[i].dv, vt[i].ilv, vt[i].xil, vt[i].yil, vt[i].clr, vt[i].persist,
               vt[i].xe, vt[i].ye);
         chk($sformatf("v%0d state", i), 32'(state_o), 32'(vt[i].st));
         chk($sformatf("v%0d trip_out", i), 32'(trip_out), 32'(vt[i].trip));
         chk($sformatf("v%0d cause", i), 32'(cause_o), 32'(vt[i].cause));
         if (vt[i].chkp) chk($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(vt[i].pend));
         chk($sformatf("v%0d trip_count", i), 32'(trip_count), 32'(vt[i].tc));
         chk($sformatf("v%0d fault_x", i), fault_x_err, vt[i].fx);
         chk($sformatf("v%0d fault_y", i), fault_y_err, vt[i].fy);
      end

      // Asynchronous reset in the middle of PENDING, between clock edges.
      drive(1,1,1,1,0,0,3,32'h0,32'h0);
      drive(1,1,1,1,0,0,3,32'h0,32'h0);
      chk("pre_reset pend_cnt", 32'(pend_cnt), 32'd2);
      chk("pre_reset state", 32'(state_o), 32'd2);
      #2 RESET_N = 1'b0;
      #1 chk_all_zero("async_reset");
      @(negedge clk);
      RESET_N = 1'b1;
      drive(0,0,0,0,0,0,3,32'h0,32'h0);
      chk("post_reset state", 32'(state_o), 32'd0);

      // trip_count saturates at all-ones.
      drive(1,0,0,0,0,0,1,32'h0,32'h0);
      exp_tc = '0;
      for (int k = 0; k < 17; k++) begin
         drive(1,1,1,1,0,0,1,32'h0,32'h0);
         if (exp_tc != '1) exp_tc = exp_tc + 1'b1;
         chk($sformatf("sat%0d trip_count", k), 32'(trip_count), 32'(exp_tc));
         drive(1,0,0,0,0,1,1,32'h0,32'h0);
      end
      chk("sat state", 32'(state_o), 32'd1);

      // No samples while ARMED.
      repeat (99) drive(1,0,0,0,0,0,1,32'h0,32'h0);
      chk("wd99 state", 32'(state_o), 32'd1);
      drive(1,0,0,0,0,0,1,32'h0,32'h0);
`ifdef MPS_AIE_TRIP_TIMEOUT_EN
      chk("wd100 state", 32'(state_o), 32'd3);
      chk("wd100 trip_out", 32'(trip_out), 32'd1);
      chk("wd100 cause", 32'(cause_o), 32'd3);
      chk("wd100 fault_x", fault_x_err, 32'h0);
`else
      chk("wd100 state", 32'(state_o), 32'd1);
      chk("wd100 trip_out", 32'(trip_out), 32'd0);
`endif
      repeat (50) drive(1,0,0,0,0,0,1,32'h0,32'h0);
`ifdef MPS_AIE_TRIP_TIMEOUT_EN
      chk("wd150 trip_out", 32'(trip_out), 32'd1);
`else
      chk("wd150 state", 32'(state_o), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
